// File: rtl/lc3b_types.sv
// Shared LC-3b physical-memory types.
package lc3b_types;

  typedef logic [15:0]  lc3b_pmem_addr;
  typedef logic [127:0] lc3b_pmem_line;

endpackage

// File: rtl/eviction_buffer_entry.sv
// Single victim-line entry: address, data and valid flag.
import lc3b_types::*;

module eviction_buffer_entry (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          clear_i,
  input  lc3b_pmem_addr addr_i,
  input  lc3b_pmem_line data_i,
  output logic          valid_o,
  output lc3b_pmem_addr addr_o,
  output lc3b_pmem_line data_o
);

  logic          valid_q, valid_d;
  lc3b_pmem_addr addr_q, addr_d;
  lc3b_pmem_line data_q, data_d;

  // clear only drops valid; the stale line is harmless
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/eviction_buffer.sv
// One-entry write-back eviction buffer between cache and memory.
import lc3b_types::*;

module eviction_buffer (
  input  logic          clk,
  input  logic          rst,
  input  logic          cache_read,
  input  logic          cache_write,
  input  lc3b_pmem_addr cache_address,
  input  lc3b_pmem_line cache_wdata,
  output lc3b_pmem_line cache_rdata,
  output logic          cache_resp,
  input  logic          pmem_resp,
  input  lc3b_pmem_line pmem_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_pmem_addr pmem_address,
  output lc3b_pmem_line pmem_wdata
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic          buf_valid;
  lc3b_pmem_addr buf_addr;
  lc3b_pmem_line buf_data;
  logic          load, clear;
  logic          resp;

  eviction_buffer_entry u_entry (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .clear_i (clear),
    .addr_i  (cache_address),
    .data_i  (cache_wdata),
    .valid_o (buf_valid),
    .addr_o  (buf_addr),
    .data_o  (buf_data)
  );

  always_comb begin
    state_d      = state_q;
    resp         = 1'b0;
    cache_rdata  = buf_data;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = buf_addr;
    pmem_wdata   = buf_data;
    load         = 1'b0;
    clear        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // read wins over write and over a pending drain
        if (cache_read) begin
          if (buf_valid && cache_address == buf_addr) begin
            resp = 1'b1;
          end else begin
            state_d = READ;
          end
        end else if (cache_write) begin
          if (!buf_valid) begin
            resp = 1'b1;
            load = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else if (buf_valid) begin
          state_d = DRAIN;
        end
      end
      READ: begin
        pmem_read    = 1'b1;
        pmem_address = cache_address;
        if (pmem_resp) begin
          resp        = 1'b1;
          cache_rdata = pmem_rdata;
          state_d     = IDLE;
        end
      end
      DRAIN: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          clear   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      resp  = 1'b0;
      load  = 1'b0;
      clear = 1'b0;
    end
  end

  assign cache_resp = resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_eviction_buffer.sv
// Scoreboard bench for the eviction buffer with a fixed-latency memory.
module tb_eviction_buffer;

  localparam int LAT = 3;
  localparam int TMO = 300;

  logic         clk = 1'b0;
  logic         rst;
  logic         cache_read, cache_write;
  logic [15:0]  cache_address;
  logic [127:0] cache_wdata, cache_rdata;
  logic         cache_resp;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;

  eviction_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .cache_read    (cache_read),
    .cache_write   (cache_write),
    .cache_address (cache_address),
    .cache_wdata   (cache_wdata),
    .cache_rdata   (cache_rdata),
    .cache_resp    (cache_resp),
    .pmem_resp     (pmem_resp),
    .pmem_rdata    (pmem_rdata),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           chk;
    logic [127:0] data;
  } cexp_t;

  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] data;
  } pexp_t;

  cexp_t exp_c[$];
  pexp_t exp_p[$];

  int total = 0;
  int bad   = 0;
  bit withhold = 1'b0;

  localparam logic [127:0] LA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] LB = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
  localparam logic [127:0] LC = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;

  function automatic logic [127:0] mem(input logic [15:0] a);
    return {8{a ^ 16'h5A5A}};
  endfunction

  task automatic check(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // memory model: answers after LAT cycles of a held command
  initial begin
    int cnt;
    cnt = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (!rst && !withhold && (pmem_read || pmem_write)) begin
        cnt++;
        if (cnt == LAT) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem(pmem_address);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // monitor: pops expectations when the DUT completes something
  always @(negedge clk) begin
    if (pmem_read && pmem_write) check("cmd_exclusive", 1, 0);
    if (cache_resp) begin
      if (exp_c.size() == 0) begin
        check("unexpected_cache_resp", 1, 0);
      end else begin
        cexp_t e;
        e = exp_c.pop_front();
        if (e.chk) check("cache_rdata", cache_rdata, e.data);
      end
    end
    if (pmem_resp && (pmem_read || pmem_write)) begin
      if (exp_p.size() == 0) begin
        check("unexpected_pmem_op", {pmem_write, pmem_address}, 0);
      end else begin
        pexp_t p;
        p = exp_p.pop_front();
        check("pmem_kind", {127'd0, pmem_write}, {127'd0, p.wr});
        check("pmem_addr", {112'd0, pmem_address}, {112'd0, p.addr});
        if (p.wr) check("pmem_wdata", pmem_wdata, p.data);
      end
    end
  end

  task automatic req(input bit rd, input bit wr, input logic [15:0] a,
                     input logic [127:0] d, output int lat);
    cache_read    = rd;
    cache_write   = wr;
    cache_address = a;
    cache_wdata   = d;
    lat = 1;
    forever begin
      @(negedge clk);
      if (cache_resp) break;
      lat++;
      if (lat > TMO) begin
        check("req_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    cache_read  = 1'b0;
    cache_write = 1'b0;
  endtask

  task automatic push_c(input bit chk, input logic [127:0] d);
    cexp_t e;
    e.chk  = chk;
    e.data = d;
    exp_c.push_back(e);
  endtask

  task automatic push_p(input bit wr, input logic [15:0] a,
                        input logic [127:0] d);
    pexp_t p;
    p.wr   = wr;
    p.addr = a;
    p.data = d;
    exp_p.push_back(p);
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    while (exp_p.size() != 0 && n < TMO) begin
      @(posedge clk);
      n++;
    end
    if (n >= TMO) check("drain_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int n;
    rst           = 1'b1;
    cache_read    = 1'b0;
    cache_write   = 1'b1;
    cache_address = 16'h1230;
    cache_wdata   = LA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp", {127'd0, cache_resp}, 0);
    check("rst_pcmd", {126'd0, pmem_read, pmem_write}, 0);
    check("rst_paddr", {112'd0, pmem_address}, 0);
    check("rst_pwdata", pmem_wdata, 0);
    check("rst_rdata", cache_rdata, 0);
    cache_write = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // write into empty buffer, then idle cycle, then drain
    push_c(0, '0);
    push_p(1, 16'h1230, LA);
    req(0, 1, 16'h1230, LA, lat);
    check("wr_empty_lat", lat, 1);
    @(negedge clk);
    check("post_acc_idle", {127'd0, pmem_write}, 0);
    @(posedge clk);
    #1;
    check("drain_pwrite", {127'd0, pmem_write}, 1);
    check("drain_paddr", {112'd0, pmem_address}, 128'h1230);
    check("drain_pwdata", pmem_wdata, LA);
    drain_wait();

    // read miss right after a write goes to memory before the drain
    push_c(0, '0);
    push_c(1, mem(16'h5670));
    push_p(0, 16'h5670, '0);
    push_p(1, 16'h1230, LA);
    req(0, 1, 16'h1230, LA, lat);
    req(1, 0, 16'h5670, '0, lat);
    check("miss_lat", lat, LAT + 1);
    drain_wait();

    // read hit in the buffer
    push_c(0, '0);
    push_c(1, LA);
    push_p(1, 16'h1230, LA);
    req(0, 1, 16'h1230, LA, lat);
    req(1, 0, 16'h1230, '0, lat);
    check("hit_lat", lat, 1);
    drain_wait();

    // back-to-back writes: second waits for the first drain
    push_c(0, '0);
    push_c(0, '0);
    push_p(1, 16'h1230, LA);
    push_p(1, 16'h2340, LB);
    req(0, 1, 16'h1230, LA, lat);
    req(0, 1, 16'h2340, LB, lat);
    check("wr_stall_lat", lat, LAT + 2);
    drain_wait();

    // reset in the middle of a drain
    withhold = 1'b1;
    push_c(0, '0);
    req(0, 1, 16'h1230, LA, lat);
    n = 0;
    while (!pmem_write && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) check("drain_start_timeout", 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_pwrite", {127'd0, pmem_write}, 0);
    check("rst_mid_valid", {127'd0, dut.u_entry.valid_o}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    withhold = 1'b0;
    push_c(1, mem(16'h1230));
    push_p(0, 16'h1230, '0);
    req(1, 0, 16'h1230, '0, lat);
    check("post_rst_miss_lat", lat, LAT + 1);
    drain_wait();

    // read and write together act as a read, nothing captured
    push_c(1, mem(16'h4000));
    push_p(0, 16'h4000, '0);
    req(1, 1, 16'h4000, LC, lat);
    check("rw_miss_lat", lat, LAT + 1);
    repeat (4) @(posedge clk);
    #1;
    check("rw_no_drain", {127'd0, pmem_write}, 0);
    push_c(1, mem(16'h4000));
    push_p(0, 16'h4000, '0);
    req(1, 0, 16'h4000, '0, lat);
    check("rw_reread_lat", lat, LAT + 1);
    drain_wait();

    repeat (3) @(posedge clk);
    check("cache_q_empty", exp_c.size(), 0);
    check("pmem_q_empty", exp_p.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
